elevator_dispatcher: RTL and testbench
======================================

Name: elevator_dispatcher

Overview:
- Request side of the elevator control interface: queues passenger trips (origin floor, destination floor) from the hall/car keypad.
- Issues trips one at a time to the elevator core over its en / in_origin / destination / emergency_stop inputs.
- Paces issues using the core's idle status, and forwards the emergency-stop button.
- Sits between the keypad decoder and the elevator core.

Parameters:
- DEPTH, 4, request FIFO entries.
- FLOORS, 5, number of valid floors (0..FLOORS-1); floor fields are 3 bits.
- ACK_TIMEOUT, 16, cycles to wait for the core to leave idle after an issue.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- req_valid  input  1  keypad presents a trip request.
- req_ready  output  1  FIFO can accept; high when count < DEPTH.
- req_origin  input  3  requested pickup floor.
- req_dest  input  3  requested destination floor.
- estop_btn  input  1  emergency button, level.
- idle  input  1  from core; 1 = core stationary and ready.
- en  output  1  issue strobe to core.
- in_origin  output  3  issued pickup floor.
- destination  output  3  issued destination floor.
- emergency_stop  output  1  to core.
- busy  output  1  1 whenever FSM is not in IDLE.
- req_count  output  3  FIFO occupancy, 0..DEPTH.
- drop  output  1  1-cycle pulse when an accepted request is discarded as invalid.
- timeout_err  output  1  sticky; set on ACK_TIMEOUT expiry, cleared only by reset.
- served_cnt  output  8  completed trips, wraps 255->0.

Behaviour:
- Reset values (sync, on clk edge with reset=1): all outputs 0, FIFO empty, FSM IDLE, timers 0. req_ready becomes 1 the cycle after reset deasserts.
- Push: req_valid && req_ready at a clk edge accepts the request.
  - If req_origin >= FLOORS or req_dest >= FLOORS: not written; drop=1 the next cycle.
  - Otherwise written at tail; req_count increments the next cycle.
  - origin == dest is valid (door cycle only).
- Push and pop on the same edge: both happen; count unchanged. Push when full: ignored, because ready is low.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HALT.
- IDLE:
  - If req_count > 0 && idle && !estop_btn: pop head, load in_origin/destination registers, go to ISSUE.
  - Outputs are valid the cycle after the pop edge.
- ISSUE:
  - en=1 for exactly 2 consecutive cycles with in_origin/destination stable, then go to WAIT_BUSY.
  - en is 0 in all other states.
- WAIT_BUSY:
  - Timer counts cycles.
  - idle==0 -> WAIT_DONE.
  - Timer reaches ACK_TIMEOUT with idle still 1 -> set timeout_err, increment served_cnt, go to IDLE.
- WAIT_DONE: idle==1 -> increment served_cnt, go to IDLE.
- in_origin/destination hold the last issued values until the next pop. They are never cleared except by reset.
- Emergency stop:
  - emergency_stop is estop_btn registered: 1-cycle latency assert and deassert.
  - From any state, estop_btn==1 -> HALT next cycle; en forced 0 immediately (combinationally gated); timer cleared.
  - Queue still accepts pushes during HALT.
  - On estop_btn==0: if HALT was entered from ISSUE/WAIT_BUSY/WAIT_DONE -> WAIT_DONE; the trip is not reissued.
  - If entered from IDLE -> IDLE.
- reset mid-trip: FIFO contents discarded, in-flight trip abandoned, outputs to reset values on that edge.
- busy = (state != IDLE).

Test Plan:
- Single trip: push (4,0); hold idle=1 -> en high exactly 2 cycles with in_origin=4, destination=0; drop idle for 10 cycles then raise -> served_cnt=1, busy=0.
- Queueing: push (1,3),(0,2),(2,4),(4,4) back-to-back while idle=0 -> req_count=4, req_ready=0; a 5th push is ignored. Release idle -> trips issued in FIFO order, each gated by an idle drop and return.
- Invalid request: push (5,2) then (7,7) -> drop pulses twice, req_count stays 0, en never asserts.
- Timeout: push (4,4); keep idle=1 -> after 2 en cycles plus 16 cycles, timeout_err=1, served_cnt increments, busy=0.
- Emergency mid-trip: push (0,2); after en, assert estop_btn 10 cycles -> emergency_stop follows with 1-cycle lag, state HALT, no en. Release with idle=1 -> served_cnt increments, with no reissue.
- Reset mid-operation: 3 requests queued, trip in WAIT_DONE; pulse reset one cycle -> req_count=0, all outputs 0, no en afterwards.

Source files
------------

// File: rtl/elevator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : elevator_dispatcher
// Brief    : Trip request FIFO and issue FSM feeding the elevator core.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_dispatcher #(
   parameter int DEPTH       = 4,
   parameter int FLOORS      = 5,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_origin,
   input  logic [2:0] req_dest,
   input  logic       estop_btn,
   input  logic       idle,
   output logic       en,
   output logic [2:0] in_origin,
   output logic [2:0] destination,
   output logic       emergency_stop,
   output logic       busy,
   output logic [2:0] req_count,
   output logic       drop,
   output logic       timeout_err,
   output logic [7:0] served_cnt
);

   localparam int             c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             c_TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [2:0]     c_DEPTH    = 3'(DEPTH);
   localparam logic [2:0]     c_FLOORS   = 3'(FLOORS);
   localparam [c_PTR_W-1:0]   c_PTR_LAST = c_PTR_W'(DEPTH - 1);
   localparam [c_PTR_W-1:0]   c_PTR_ONE  = c_PTR_W'(1);
   localparam [c_TMR_W-1:0]   c_TMR_LAST = c_TMR_W'(ACK_TIMEOUT - 1);
   localparam [c_TMR_W-1:0]   c_TMR_ONE  = c_TMR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [5:0]           r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [2:0]           r_count;
   logic [2:0]           w_count_next;
   logic [c_TMR_W-1:0]   r_timer;
   logic                 r_issue_cnt;
   logic                 r_halt_trip;
   logic                 w_push;
   logic                 w_req_ok;
   logic                 w_wr;
   logic                 w_pop;
   logic                 w_served_inc;
   logic                 w_timeout_set;

   assign w_push    = req_valid && req_ready;
   assign w_req_ok  = (req_origin < c_FLOORS) && (req_dest < c_FLOORS);
   assign w_wr      = w_push && w_req_ok;
   assign req_count = r_count;
   assign busy      = (r_state != S_IDLE);
   // Gated directly by the button so the strobe drops in the same cycle.
   assign en        = (r_state == S_ISSUE) && !estop_btn;

   always_comb begin
      w_count_next = r_count;
      if (w_wr && !w_pop) begin
         w_count_next = r_count + 3'd1;
      end else if (!w_wr && w_pop) begin
         w_count_next = r_count - 3'd1;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_pop         = 1'b0;
      w_served_inc  = 1'b0;
      w_timeout_set = 1'b0;
      if (estop_btn) begin
         w_state_next = S_HALT;
      end else begin
         case (r_state)
            S_IDLE: begin
               if ((r_count != 3'd0) && idle) begin
                  w_pop        = 1'b1;
                  w_state_next = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (r_issue_cnt) w_state_next = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (!idle) begin
                  w_state_next = S_WAIT_DONE;
               end else if (r_timer == c_TMR_LAST) begin
                  w_timeout_set = 1'b1;
                  w_served_inc  = 1'b1;
                  w_state_next  = S_IDLE;
               end
            end
            S_WAIT_DONE: begin
               if (idle) begin
                  w_served_inc = 1'b1;
                  w_state_next = S_IDLE;
               end
            end
            S_HALT: begin
               // An interrupted trip is never reissued; just wait for the core to settle.
               w_state_next = r_halt_trip ? S_WAIT_DONE : S_IDLE;
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= 3'd0;
         r_timer        <= '0;
         r_issue_cnt    <= 1'b0;
         r_halt_trip    <= 1'b0;
         req_ready      <= 1'b0;
         in_origin      <= 3'd0;
         destination    <= 3'd0;
         emergency_stop <= 1'b0;
         drop           <= 1'b0;
         timeout_err    <= 1'b0;
         served_cnt     <= 8'd0;
      end else begin
         r_state        <= w_state_next;
         r_count        <= w_count_next;
         req_ready      <= (w_count_next < c_DEPTH);
         emergency_stop <= estop_btn;
         drop           <= w_push && !w_req_ok;
         r_issue_cnt    <= (r_state == S_ISSUE) && !r_issue_cnt && !estop_btn;
         r_timer        <= ((r_state == S_WAIT_BUSY) && (w_state_next == S_WAIT_BUSY))
                           ? r_timer + c_TMR_ONE : '0;
         if (estop_btn && (r_state != S_HALT)) r_halt_trip <= (r_state != S_IDLE);
         if (w_timeout_set) timeout_err <= 1'b1;
         if (w_served_inc) served_cnt <= served_cnt + 8'd1;
         if (w_pop) begin
            {in_origin, destination} <= r_mem[r_rd_ptr];
            r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
         end
         if (w_wr) begin
            r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
         end
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= {req_origin, req_dest};
   end

endmodule
`default_nettype wire

// File: tb/tb_elevator_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_dispatcher
// Brief    : Directed stimulus with a trip scoreboard for elevator_dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_dispatcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_origin;
   logic [2:0] req_dest;
   logic       estop_btn;
   logic       idle;
   logic       en;
   logic [2:0] in_origin;
   logic [2:0] destination;
   logic       emergency_stop;
   logic       busy;
   logic [2:0] req_count;
   logic       drop;
   logic       timeout_err;
   logic [7:0] served_cnt;

   int         n_vec = 0;
   int         n_err = 0;
   logic [5:0] exp_q [$];
   logic [5:0] r_trip;
   int         en_len = 0;

   always #5 clk = ~clk;

   elevator_dispatcher #(.DEPTH(4), .FLOORS(5), .ACK_TIMEOUT(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_origin     (req_origin),
      .req_dest       (req_dest),
      .estop_btn      (estop_btn),
      .idle           (idle),
      .en             (en),
      .in_origin      (in_origin),
      .destination    (destination),
      .emergency_stop (emergency_stop),
      .busy           (busy),
      .req_count      (req_count),
      .drop           (drop),
      .timeout_err    (timeout_err),
      .served_cnt     (served_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // issue=1 means this request is expected to reach the core as a trip.
   task automatic push(input logic [2:0] o, input logic [2:0] d, input bit issue);
      req_origin = o;
      req_dest   = d;
      req_valid  = 1'b1;
      if (issue) exp_q.push_back({o, d});
      @(negedge clk);
      req_valid  = 1'b0;
   endtask

   task automatic serve_trip(input int low_cycles);
      int k;
      idle = 1'b1;
      k = 0;
      while (!en && k < 30) begin tick(1); k++; end
      chk("trip_start", int'(en), 1);
      k = 0;
      while (en && k < 10) begin tick(1); k++; end
      chk("trip_en_end", int'(en), 0);
      idle = 1'b0;
      tick(low_cycles);
      idle = 1'b1;
      tick(1);
   endtask

   // Monitor: each en burst must match the next queued trip and last 2 cycles.
   always @(negedge clk) begin
      if (reset) begin
         en_len = 0;
      end else if (en) begin
         if (en_len == 0) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_en: trip %0d->%0d issued, none expected at %0t",
                        in_origin, destination, $time);
            end else begin
               r_trip = exp_q.pop_front();
               chk("trip_origin", in_origin, r_trip[5:3]);
               chk("trip_dest", destination, r_trip[2:0]);
            end
         end
         en_len++;
      end else if (en_len != 0) begin
         chk("en_length", en_len, 2);
         en_len = 0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_origin = 3'd0;
      req_dest   = 3'd0;
      estop_btn  = 1'b0;
      idle       = 1'b1;
      tick(3);
      chk("rst_ready", req_ready, 0);
      chk("rst_count", req_count, 0);
      chk("rst_en", en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_served", served_cnt, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_estop", emergency_stop, 0);
      chk("rst_drop", drop, 0);
      reset = 1'b0;
      tick(1);
      chk("ready_after_rst", req_ready, 1);

      // Single trip
      push(3'd4, 3'd0, 1'b1);
      chk("t1_count", req_count, 1);
      tick(1);
      chk("t1_en0", en, 1);
      chk("t1_origin", in_origin, 4);
      chk("t1_dest", destination, 0);
      chk("t1_busy", busy, 1);
      chk("t1_count_pop", req_count, 0);
      tick(1);
      chk("t1_en1", en, 1);
      tick(1);
      chk("t1_en2", en, 0);
      idle = 1'b0;
      tick(10);
      chk("t1_busy_wait", busy, 1);
      idle = 1'b1;
      tick(1);
      chk("t1_served", served_cnt, 1);
      chk("t1_idle", busy, 0);

      // Queueing up to full, then drain in order
      idle = 1'b0;
      push(3'd1, 3'd3, 1'b1);
      push(3'd0, 3'd2, 1'b1);
      push(3'd2, 3'd4, 1'b1);
      push(3'd4, 3'd4, 1'b1);
      chk("q_count_full", req_count, 4);
      chk("q_ready_full", req_ready, 0);
      push(3'd3, 3'd1, 1'b0);
      chk("q_count_ignored", req_count, 4);
      for (int i = 0; i < 4; i++) serve_trip(3);
      chk("q_served", served_cnt, 5);
      chk("q_count_empty", req_count, 0);
      chk("q_ready_empty", req_ready, 1);
      chk("q_busy", busy, 0);

      // Invalid requests
      push(3'd5, 3'd2, 1'b0);
      chk("inv_drop0", drop, 1);
      push(3'd7, 3'd7, 1'b0);
      chk("inv_drop1", drop, 1);
      tick(1);
      chk("inv_drop_clr", drop, 0);
      chk("inv_count", req_count, 0);
      tick(3);
      chk("inv_busy", busy, 0);

      // Timeout with idle stuck high
      push(3'd4, 3'd4, 1'b1);
      tick(18);
      chk("to_pending", timeout_err, 0);
      chk("to_busy", busy, 1);
      tick(1);
      chk("to_set", timeout_err, 1);
      chk("to_served", served_cnt, 6);
      chk("to_idle", busy, 0);

      // Emergency stop during WAIT_DONE
      push(3'd0, 3'd2, 1'b1);
      tick(3);
      chk("es_wait_busy", busy, 1);
      idle = 1'b0;
      tick(1);
      estop_btn = 1'b1;
      chk("es_lag_on", emergency_stop, 0);
      tick(1);
      chk("es_on", emergency_stop, 1);
      chk("es_en", en, 0);
      chk("es_busy", busy, 1);
      tick(9);
      chk("es_hold", emergency_stop, 1);
      estop_btn = 1'b0;
      idle = 1'b1;
      tick(1);
      chk("es_lag_off", emergency_stop, 0);
      chk("es_served_hold", served_cnt, 6);
      chk("es_busy_done", busy, 1);
      tick(1);
      chk("es_served", served_cnt, 7);
      chk("es_idle", busy, 0);
      tick(5);
      chk("es_no_reissue", en, 0);

      // Reset mid-operation
      push(3'd3, 3'd1, 1'b1);
      tick(3);
      idle = 1'b0;
      tick(1);
      chk("rm_busy", busy, 1);
      push(3'd1, 3'd2, 1'b0);
      push(3'd2, 3'd3, 1'b0);
      push(3'd0, 3'd1, 1'b0);
      chk("rm_count", req_count, 3);
      reset = 1'b1;
      tick(1);
      chk("rm_count_clr", req_count, 0);
      chk("rm_busy_clr", busy, 0);
      chk("rm_ready", req_ready, 0);
      chk("rm_origin", in_origin, 0);
      chk("rm_dest", destination, 0);
      chk("rm_served", served_cnt, 0);
      chk("rm_timeout", timeout_err, 0);
      reset = 1'b0;
      tick(1);
      chk("rm_ready_back", req_ready, 1);
      idle = 1'b1;
      tick(10);
      chk("rm_no_en", en, 0);
      chk("rm_idle", busy, 0);

      chk("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
